// File: rtl/booth_seq_mult_if.sv
// ---------------------------------------------------------------------------
// booth_seq_mult_if
//
// Purpose:
//   Bundles the start/done handshake, the operand bus and the product bus of
//   the sequential Booth multiplier. The clock and reset stay outside as plain
//   module ports.
//
// Parameters:
//   N             operand width in bits (product is 2N bits)
//
// Signals:
//   start         request from the operand side, sampled in IDLE or DONE
//   multiplicand  signed operand M (N bits)
//   multiplier    signed operand Q (N bits)
//   busy          high while the multiplier is stepping
//   done          one-cycle pulse when a product becomes valid
//   product       signed result M*Q (2N bits), held until the next job ends
//
// Modports:
//   master        operand/result side (drives start and operands)
//   slave         the multiplier itself (drives busy, done, product)
// ---------------------------------------------------------------------------
interface booth_seq_mult_if #(
  parameter int N = 8
) ();

  logic           start;
  logic [N-1:0]   multiplicand;
  logic [N-1:0]   multiplier;
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;

  modport master (
    output start,
    output multiplicand,
    output multiplier,
    input  busy,
    input  done,
    input  product
  );

  modport slave (
    input  start,
    input  multiplicand,
    input  multiplier,
    output busy,
    output done,
    output product
  );

endinterface

// File: rtl/booth_seq_mult.sv
// ---------------------------------------------------------------------------
// booth_seq_mult
//
// Purpose:
//   Sequential radix-2 Booth multiplier for N-bit two's-complement operands.
//   One Booth step retires per clock, so a job occupies the unit for N RUN
//   cycles followed by a single DONE cycle. The accumulator is N+1 bits wide
//   so that the most negative multiplicand can be negated without overflow.
//
// Parameters:
//   N             operand width in bits, N >= 2; product width is 2N
//
// Ports:
//   clk           single clock, all state changes on the rising edge
//   rst_n         synchronous active-low reset
//   bus           booth_seq_mult_if slave modport:
//                   start, multiplicand, multiplier  (inputs)
//                   busy, done, product              (outputs)
//
// Output timing:
//   busy and done are decoded from the state register and product is a
//   register of its own, so no input reaches an output combinationally.
//   A start accepted at edge E0 raises done after edge E0+N.
// ---------------------------------------------------------------------------
module booth_seq_mult #(
  parameter int N = 8
) (
  input logic             clk,
  input logic             rst_n,
  booth_seq_mult_if.slave bus
);

  // Counter must be able to hold the value N itself.
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         state_next;

  logic           accept;
  logic           last_step;

  // Booth working registers: {a_reg, q_reg, q_1} is the shifting triple.
  logic [N:0]     m_reg;
  logic [N:0]     a_reg;
  logic [N-1:0]   q_reg;
  logic           q_1;
  logic [CW-1:0]  count;

  // Result of one Booth step, computed from the current working registers.
  logic [N:0]     sum;
  logic [N:0]     a_shift;
  logic [N-1:0]   q_shift;
  logic           q_1_shift;

  logic [2*N-1:0] product_reg;

  // ------------------------------------------------------------------------
  // State register
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ------------------------------------------------------------------------
  // Next-state logic. A new job can be accepted from DONE as well as IDLE,
  // which is what gives back-to-back throughput of one result per N+1 cycles
  // when start is held high. In RUN the start input is not looked at.
  // ------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last_step  = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end

      RUN: begin
        if (count == CW'(1)) begin
          last_step  = 1'b1;
          state_next = DONE;
        end
      end

      DONE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------------
  // One Booth step. The pair {Q[0], q_1} selects add, subtract or nothing;
  // subtraction is A + ~M + 1 on the N+1-bit datapath and the carry-out is
  // simply dropped. The arithmetic right shift then replicates the sign of
  // the freshly updated accumulator into the top bit.
  // ------------------------------------------------------------------------
  always_comb begin
    sum = a_reg;

    case ({q_reg[0], q_1})
      2'b01:   sum = a_reg + m_reg;
      2'b10:   sum = a_reg + ~m_reg + {{N{1'b0}}, 1'b1};
      default: sum = a_reg;
    endcase

    a_shift   = {sum[N], sum[N:1]};
    q_shift   = {sum[0], q_reg[N-1:1]};
    q_1_shift = q_reg[0];
  end

  // ------------------------------------------------------------------------
  // Working registers and count. Operands are captured only on an accepted
  // start, so changes on the operand bus during RUN have no effect.
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_reg <= '0;
      a_reg <= '0;
      q_reg <= '0;
      q_1   <= 1'b0;
      count <= '0;
    end else if (accept) begin
      m_reg <= {bus.multiplicand[N-1], bus.multiplicand};
      a_reg <= '0;
      q_reg <= bus.multiplier;
      q_1   <= 1'b0;
      count <= CW'(N);
    end else if (state == RUN) begin
      a_reg <= a_shift;
      q_reg <= q_shift;
      q_1   <= q_1_shift;
      count <= count - CW'(1);
    end
  end

  // ------------------------------------------------------------------------
  // Product register. It is loaded from the post-step values on the edge
  // that retires the last step, so it becomes valid together with done.
  // The product always fits in 2N bits, so the accumulator's extra top bit
  // carries no information at this point.
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      product_reg <= '0;
    end else if (last_step) begin
      product_reg <= {a_shift[N-1:0], q_shift};
    end
  end

  assign bus.busy    = (state == RUN);
  assign bus.done    = (state == DONE);
  assign bus.product = product_reg;

endmodule

// File: tb/tb_booth_seq_mult.sv
// ---------------------------------------------------------------------------
// tb_booth_seq_mult
//
// Purpose:
//   Self-checking bench for booth_seq_mult. Three instances run side by side:
//   N=8 for directed and random jobs, N=4 for every operand pair, and N=16
//   for random pairs. Stimulus pushes the expected product into a per-instance
//   queue; a separate monitor per instance pops and compares on every done.
//   Expected products come from plain signed integer multiplication or from
//   constants worked out by hand.
// ---------------------------------------------------------------------------
module tb_booth_seq_mult;

  logic clk;
  logic rst_n;
  logic rst4_n;
  logic rst16_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  booth_seq_mult_if #(.N(8))  bus8  ();
  booth_seq_mult_if #(.N(4))  bus4  ();
  booth_seq_mult_if #(.N(16)) bus16 ();

  booth_seq_mult #(.N(8))  dut8  (.clk(clk), .rst_n(rst_n),   .bus(bus8));
  booth_seq_mult #(.N(4))  dut4  (.clk(clk), .rst_n(rst4_n),  .bus(bus4));
  booth_seq_mult #(.N(16)) dut16 (.clk(clk), .rst_n(rst16_n), .bus(bus16));

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;

  logic [15:0] exp8  [$];
  logic [7:0]  exp4  [$];
  logic [31:0] exp16 [$];

  int          done8_cnt = 0;
  int          done8_time [$];
  logic        prev8  = 1'b0;
  logic        prev4  = 1'b0;
  logic        prev16 = 1'b0;
  bit          aux4_fin  = 1'b0;
  bit          aux16_fin = 1'b0;

  // Hand-computed corner products for N=8.
  logic [7:0]  tab_m [8] = '{8'h80, 8'h80, 8'h7F, 8'h00, 8'hFF, 8'h80, 8'h00, 8'h80};
  logic [7:0]  tab_q [8] = '{8'h80, 8'h7F, 8'h7F, 8'h80, 8'hFF, 8'hFF, 8'h00, 8'h01};
  logic [15:0] tab_e [8] = '{16'h4000, 16'hC080, 16'h3F01, 16'h0000,
                             16'h0001, 16'h0080, 16'h0000, 16'hFF80};

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: ordinary signed multiplication on wide integers.
  function automatic longint mul(input longint a, input longint b);
    return a * b;
  endfunction

  // Random N=8 operand with a bias towards the awkward values.
  function automatic logic [7:0] pick8();
    case ($urandom_range(0, 7))
      0:       return 8'h80;
      1:       return 8'hFF;
      2:       return 8'h00;
      3:       return 8'h7F;
      default: return 8'($urandom());
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic reportTimeout(input string name);
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s: bound expired, got no response, expected one (t=%0t)", name, $time);
  endtask

  // All main-sequence actions happen 1 time unit after a rising edge.
  task automatic waitIdle8();
    int n = 0;
    while (bus8.busy === 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) reportTimeout("dut8 wait for idle");
  endtask

  task automatic waitDone8(output int edges);
    edges = 0;
    while (bus8.done !== 1'b1 && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
    if (edges >= 100) reportTimeout("dut8 wait for done");
  endtask

  task automatic applyStimulus(input logic [7:0] m, input logic [7:0] q, input logic [15:0] exp);
    waitIdle8();
    bus8.multiplicand = m;
    bus8.multiplier   = q;
    bus8.start        = 1'b1;
    exp8.push_back(exp);
    @(posedge clk); #1;
    bus8.start = 1'b0;
  endtask

  // Monitors: one per instance, comparing on every done pulse.
  initial forever begin
    @(negedge clk);
    if (bus8.done === 1'b1) begin
      checkOutput("dut8 done pulse width", 32'(prev8), 32'd0);
      done8_cnt++;
      done8_time.push_back(cyc);
      if (exp8.size() == 0) reportTimeout("dut8 done with empty scoreboard");
      else checkOutput("dut8 product", 32'(bus8.product), 32'(exp8.pop_front()));
    end
    prev8 = bus8.done;
  end

  initial forever begin
    @(negedge clk);
    if (bus4.done === 1'b1) begin
      checkOutput("dut4 done pulse width", 32'(prev4), 32'd0);
      if (exp4.size() == 0) reportTimeout("dut4 done with empty scoreboard");
      else checkOutput("dut4 product", 32'(bus4.product), 32'(exp4.pop_front()));
    end
    prev4 = bus4.done;
  end

  initial forever begin
    @(negedge clk);
    if (bus16.done === 1'b1) begin
      checkOutput("dut16 done pulse width", 32'(prev16), 32'd0);
      if (exp16.size() == 0) reportTimeout("dut16 done with empty scoreboard");
      else checkOutput("dut16 product", bus16.product, exp16.pop_front());
    end
    prev16 = bus16.done;
  end

  // N=4: every operand pair.
  initial begin
    logic [3:0] m4;
    logic [3:0] q4;
    int         n;
    rst4_n = 1'b0;
    bus4.start = 1'b0;
    bus4.multiplicand = '0;
    bus4.multiplier = '0;
    repeat (3) @(posedge clk);
    #1 rst4_n = 1'b1;
    for (int m = 0; m < 16; m++) begin
      for (int q = 0; q < 16; q++) begin
        n = 0;
        while (bus4.busy === 1'b1 && n < 50) begin
          @(posedge clk); #1;
          n++;
        end
        if (n >= 50) reportTimeout("dut4 wait for idle");
        m4 = 4'(m);
        q4 = 4'(q);
        bus4.multiplicand = m4;
        bus4.multiplier   = q4;
        bus4.start        = 1'b1;
        exp4.push_back(8'(mul(longint'($signed(m4)), longint'($signed(q4)))));
        @(posedge clk); #1;
        bus4.start = 1'b0;
      end
    end
    repeat (10) @(posedge clk);
    aux4_fin = 1'b1;
  end

  // N=16: random pairs, about half of them with a corner value mixed in.
  initial begin
    logic [15:0] m16;
    logic [15:0] q16;
    int          n;
    rst16_n = 1'b0;
    bus16.start = 1'b0;
    bus16.multiplicand = '0;
    bus16.multiplier = '0;
    repeat (3) @(posedge clk);
    #1 rst16_n = 1'b1;
    for (int j = 0; j < 1500; j++) begin
      n = 0;
      while (bus16.busy === 1'b1 && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
      if (n >= 100) reportTimeout("dut16 wait for idle");
      m16 = 16'($urandom());
      q16 = 16'($urandom());
      if (j % 4 == 1) m16 = 16'h8000;
      if (j % 8 == 3) q16 = 16'hFFFF;
      bus16.multiplicand = m16;
      bus16.multiplier   = q16;
      bus16.start        = 1'b1;
      exp16.push_back(32'(mul(longint'($signed(m16)), longint'($signed(q16)))));
      @(posedge clk); #1;
      bus16.start = 1'b0;
    end
    repeat (25) @(posedge clk);
    aux16_fin = 1'b1;
  end

  // Main N=8 sequence.
  initial begin
    int         edges;
    int         busy_cyc;
    int         base;
    int         t0;
    int         n;
    logic [7:0] rm;
    logic [7:0] rq;

    rst_n = 1'b0;
    bus8.start = 1'b0;
    bus8.multiplicand = '0;
    bus8.multiplier = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    checkOutput("reset busy", 32'(bus8.busy), 32'd0);
    checkOutput("reset done", 32'(bus8.done), 32'd0);
    checkOutput("reset product", 32'(bus8.product), 32'd0);

    // 3 * -4: latency and busy occupancy.
    applyStimulus(8'd3, 8'hFC, 16'hFFF4);
    edges = 0;
    busy_cyc = 0;
    while (bus8.done !== 1'b1 && edges < 40) begin
      if (bus8.busy === 1'b1) busy_cyc++;
      @(posedge clk); #1;
      edges++;
    end
    checkOutput("accept-to-done edges", edges, 32'd8);
    checkOutput("busy cycles", busy_cyc, 32'd8);
    checkOutput("busy low with done", 32'(bus8.busy), 32'd0);
    checkOutput("product 3*-4", 32'(bus8.product), 32'h0000FFF4);

    // Corner operand table.
    for (int i = 0; i < 8; i++) applyStimulus(tab_m[i], tab_q[i], tab_e[i]);

    // Start pulses with fresh operands during RUN cycles 2..5 are ignored.
    applyStimulus(8'd5, 8'd9, 16'd45);
    base = done8_cnt;
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      bus8.start        = 1'b1;
      bus8.multiplicand = 8'($urandom());
      bus8.multiplier   = 8'($urandom());
      @(posedge clk); #1;
    end
    bus8.start = 1'b0;
    waitDone8(edges);
    @(posedge clk); #1;
    checkOutput("done count with start in RUN", done8_cnt - base, 32'd1);

    // Reset at the edge that would retire step 3.
    applyStimulus(8'd7, 8'd11, 16'd77);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    void'(exp8.pop_back());
    base = done8_cnt;
    checkOutput("abort busy", 32'(bus8.busy), 32'd0);
    checkOutput("abort done", 32'(bus8.done), 32'd0);
    checkOutput("abort product", 32'(bus8.product), 32'd0);
    repeat (12) @(posedge clk);
    #1 checkOutput("no done after abort", done8_cnt - base, 32'd0);
    applyStimulus(8'd5, 8'hF9, 16'hFFDD);
    waitDone8(edges);
    repeat (2) @(posedge clk);
    #1;

    // Start held high across three jobs.
    t0 = done8_time.size();
    bus8.start = 1'b1;
    bus8.multiplicand = 8'd2;
    bus8.multiplier   = 8'd3;
    exp8.push_back(16'd6);
    @(posedge clk); #1;
    bus8.multiplicand = 8'hFF;
    bus8.multiplier   = 8'hFF;
    exp8.push_back(16'd1);
    waitDone8(edges);
    @(posedge clk); #1;
    bus8.multiplicand = 8'h00;
    bus8.multiplier   = 8'h80;
    exp8.push_back(16'd0);
    waitDone8(edges);
    @(posedge clk); #1;
    bus8.start = 1'b0;
    waitDone8(edges);
    @(posedge clk); #1;
    checkOutput("jobs with start held", done8_time.size() - t0, 32'd3);
    if (done8_time.size() >= t0 + 3) begin
      checkOutput("done spacing 1-2", done8_time[t0 + 1] - done8_time[t0], 32'd9);
      checkOutput("done spacing 2-3", done8_time[t0 + 2] - done8_time[t0 + 1], 32'd9);
    end else begin
      reportTimeout("held-start done pulses");
    end

    // Random jobs, some issued straight from DONE.
    for (int j = 0; j < 200; j++) begin
      rm = pick8();
      rq = pick8();
      applyStimulus(rm, rq, 16'(mul(longint'($signed(rm)), longint'($signed(rq)))));
    end
    waitDone8(edges);
    repeat (3) @(posedge clk);

    n = 0;
    while ((!aux4_fin || !aux16_fin) && n < 60000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 60000) reportTimeout("auxiliary instances finish");
    #1;
    checkOutput("dut8 scoreboard drained", exp8.size(), 32'd0);
    checkOutput("dut4 scoreboard drained", exp4.size(), 32'd0);
    checkOutput("dut16 scoreboard drained", exp16.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
